// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift sequencer.
package ecp5pll_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE
    } state_t;

    localparam logic DIR_DELAY   = 1'b0;
    localparam logic DIR_ADVANCE = 1'b1;

    localparam int N_OUT = 4;
    localparam int TMR_W = 16;

endpackage

// File: rtl/ecp5pll_phase_timer.sv
// Loadable down-counter shared by the lock-qualify, setup, pulse and gap intervals.
module ecp5pll_phase_timer #(
    parameter int           W         = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= RESET_VAL;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP for shift requests, gated on PLL lock,
// and tracks a cumulative phase position per PLL output.
module ecp5pll_phase_ctrl
    import ecp5pll_pkg::*;
#(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 8,
    parameter int LOCK_CYC  = 16,
    parameter int STEPS_W   = 8,
    parameter int POS_W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   pll_locked_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_sel_i,
    input  logic                   req_dir_i,
    input  logic [STEPS_W-1:0]     req_steps_i,
    output logic [1:0]             phasesel_o,
    output logic                   phasedir_o,
    output logic                   phasestep_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [N_OUT*POS_W-1:0] pos_o
);

    state_t             state_reg;
    logic [1:0]         sel_reg;
    logic               dir_reg;
    logic [STEPS_W-1:0] steps_reg;
    logic               step_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic               ready_reg;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expired;

    logic               lock_lost;
    logic               accept;
    logic               gap_exit;

    assign lock_lost = (state_reg != WAIT_LOCK) && !pll_locked_i;
    assign accept    = (state_reg == IDLE) && req_valid_i && pll_locked_i;
    assign gap_exit  = (state_reg == GAP) && tmr_expired && pll_locked_i;

    // A timer holding LOCK_CYC means zero qualified lock cycles so far.
    ecp5pll_phase_timer #(
        .W         (TMR_W),
        .RESET_VAL (TMR_W'(LOCK_CYC))
    ) u_timer (
        .clk      (clk_i),
        .rstn     (rstn_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!pll_locked_i) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCK_CYC);
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETUP_CYC - 1);
                end
                SETUP: if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYC - 1);
                end
                PULSE: if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYC - 1);
                end
                GAP: if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYC - 1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= WAIT_LOCK;
            sel_reg   <= '0;
            dir_reg   <= DIR_DELAY;
            steps_reg <= '0;
            step_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (lock_lost) begin
                state_reg <= WAIT_LOCK;
                step_reg  <= 1'b0;
                busy_reg  <= 1'b0;
                ready_reg <= 1'b0;
                if (state_reg != IDLE) begin
                    err_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    WAIT_LOCK: if (pll_locked_i && tmr_expired) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                    IDLE: if (accept) begin
                        sel_reg   <= req_sel_i;
                        dir_reg   <= req_dir_i;
                        steps_reg <= req_steps_i;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                        if (req_steps_i != '0) begin
                            state_reg <= SETUP;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    SETUP: if (tmr_expired) begin
                        state_reg <= PULSE;
                        step_reg  <= 1'b1;
                    end
                    PULSE: if (tmr_expired) begin
                        state_reg <= GAP;
                        step_reg  <= 1'b0;
                    end
                    GAP: if (tmr_expired) begin
                        steps_reg <= steps_reg - STEPS_W'(1);
                        if (steps_reg == STEPS_W'(1)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= PULSE;
                            step_reg  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                    default: state_reg <= WAIT_LOCK;
                endcase
            end
        end
    end

    // A step only counts once its gap has fully elapsed under lock.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_pos
            logic [POS_W-1:0] pos_reg;
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    pos_reg <= '0;
                end else if (gap_exit && (sel_reg == 2'(gi))) begin
                    pos_reg <= (dir_reg == DIR_DELAY) ? pos_reg + POS_W'(1)
                                                      : pos_reg - POS_W'(1);
                end
            end
            assign pos_o[gi*POS_W +: POS_W] = pos_reg;
        end
    endgenerate

    assign req_ready_o = ready_reg;
    assign phasesel_o  = sel_reg;
    assign phasedir_o  = dir_reg;
    assign phasestep_o = step_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed, table-driven bench for the PLL phase-shift sequencer.
module tb_ecp5pll_phase_ctrl;

    localparam int STEPS_W = 8;
    localparam int POS_W   = 8;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               pll_locked_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [1:0]         req_sel_i;
    logic               req_dir_i;
    logic [STEPS_W-1:0] req_steps_i;
    logic [1:0]         phasesel_o;
    logic               phasedir_o;
    logic               phasestep_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [4*POS_W-1:0] pos_o;

    always #5 clk_i = ~clk_i;

    ecp5pll_phase_ctrl #(
        .SETUP_CYC (4),
        .PULSE_CYC (4),
        .GAP_CYC   (8),
        .LOCK_CYC  (16),
        .STEPS_W   (STEPS_W),
        .POS_W     (POS_W)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .pll_locked_i (pll_locked_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_sel_i    (req_sel_i),
        .req_dir_i    (req_dir_i),
        .req_steps_i  (req_steps_i),
        .phasesel_o   (phasesel_o),
        .phasedir_o   (phasedir_o),
        .phasestep_o  (phasestep_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .pos_o        (pos_o)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        dir;
        logic [7:0]  steps;
        int          done_lat;
        int          first_rise;
        int          pulses;
        int          high_cyc;
        logic [31:0] pos;
    } vec_t;

    vec_t vecs[6];
    vec_t v_zero;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        while (!req_ready_o && waited < 200) begin
            tick();
            waited++;
        end
        chk({tag, "_ready_wait"}, 32'(req_ready_o), 32'd1);
    endtask

    task automatic run_req(input vec_t v, input string tag);
        int   rel = 1;
        int   first = -1;
        int   pulses = 0;
        int   high = 0;
        int   done_lat = -1;
        logic prev = 1'b0;
        logic sel_ok = 1'b1;
        logic err_after;
        logic ready_after;
        wait_ready(tag);
        req_valid_i = 1'b1;
        req_sel_i   = v.sel;
        req_dir_i   = v.dir;
        req_steps_i = v.steps;
        tick();
        req_valid_i = 1'b0;
        err_after   = err_o;
        while (rel <= 300) begin
            if (phasestep_o && !prev) begin
                pulses++;
                if (first < 0) first = rel;
            end
            if (phasestep_o) high++;
            prev = phasestep_o;
            if (phasesel_o !== v.sel || phasedir_o !== v.dir) sel_ok = 1'b0;
            if (done_o) begin
                done_lat = rel;
                break;
            end
            tick();
            rel++;
        end
        tick();
        ready_after = req_ready_o;
        chk({tag, "_done_lat"},   32'(done_lat),  32'(v.done_lat));
        chk({tag, "_first_rise"}, 32'(first),     32'(v.first_rise));
        chk({tag, "_pulses"},     32'(pulses),    32'(v.pulses));
        chk({tag, "_high_cyc"},   32'(high),      32'(v.high_cyc));
        chk({tag, "_sel_stable"}, 32'(sel_ok),    32'd1);
        chk({tag, "_err_clear"},  32'(err_after), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready_after), 32'd1);
        chk({tag, "_pos"},        pos_o,          v.pos);
        $display("req %s sel=%0d dir=%0d steps=%0d done_lat=%0d pulses=%0d pos=%08h",
                 tag, v.sel, v.dir, v.steps, done_lat, pulses, pos_o);
    endtask

    initial begin
        int   rel;
        logic flag;

        rstn_i       = 1'b0;
        pll_locked_i = 1'b1;
        req_valid_i  = 1'b0;
        req_sel_i    = 2'd0;
        req_dir_i    = 1'b0;
        req_steps_i  = '0;

        // sel, dir, steps, done latency, first rise, pulses, high cycles, pos after
        vecs[0] = '{2'd2, 1'b0, 8'd3, 41,  5, 3, 12, 32'h00030000};
        vecs[1] = '{2'd1, 1'b1, 8'd1, 17,  5, 1,  4, 32'h0003FF00};
        vecs[2] = '{2'd0, 1'b0, 8'd0,  1, -1, 0,  0, 32'h0003FF00};
        vecs[3] = '{2'd3, 1'b0, 8'd2, 29,  5, 2,  8, 32'h0203FF00};
        vecs[4] = '{2'd1, 1'b0, 8'd2, 29,  5, 2,  8, 32'h02030100};
        vecs[5] = '{2'd2, 1'b1, 8'd5, 65,  5, 5, 20, 32'h02FE0100};
        v_zero  = '{2'd0, 1'b1, 8'd0,  1, -1, 0,  0, 32'h02FE0101};

        repeat (3) tick();
        chk("reset_pos",   pos_o, 32'd0);
        chk("reset_ready", 32'(req_ready_o), 32'd0);
        chk("reset_outs",  32'({phasesel_o, phasedir_o, phasestep_o, busy_o, done_o, err_o}), 32'd0);

        // Lock qualification: ready must appear exactly in cycle 17.
        rstn_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k < 17) chk($sformatf("lockwait_ready_c%0d", k), 32'(req_ready_o), 32'd0);
            else        chk("lockwait_ready_c17", 32'(req_ready_o), 32'd1);
            if (k == 16) begin
                chk("lockwait_pos", pos_o, 32'd0);
                chk("lockwait_outs", 32'({phasesel_o, phasedir_o, phasestep_o, busy_o, done_o, err_o}), 32'd0);
            end
        end

        for (int i = 0; i < 6; i++) run_req(vecs[i], $sformatf("v%0d", i));

        // Lock loss during the second pulse of a 4-step request.
        wait_ready("lockloss");
        req_valid_i = 1'b1;
        req_sel_i   = 2'd0;
        req_dir_i   = 1'b0;
        req_steps_i = 8'd4;
        tick();
        req_valid_i = 1'b0;
        rel = 1;
        while (rel < 18) begin
            tick();
            rel++;
        end
        chk("lockloss_in_pulse2", 32'(phasestep_o), 32'd1);
        pll_locked_i = 1'b0;
        tick();
        chk("lockloss_step", 32'(phasestep_o), 32'd0);
        chk("lockloss_err",  32'(err_o),       32'd1);
        chk("lockloss_busy", 32'(busy_o),      32'd0);
        chk("lockloss_ready", 32'(req_ready_o), 32'd0);
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done_o) flag = 1'b1;
            tick();
        end
        chk("lockloss_no_done", 32'(flag), 32'd0);
        chk("lockloss_pos", pos_o, 32'h02FE0101);
        $display("req lockloss sel=0 steps=4 err=%0d pos=%08h", err_o, pos_o);
        pll_locked_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) chk("relock_ready_c16", 32'(req_ready_o), 32'd0);
            if (k == 17) begin
                chk("relock_ready_c17", 32'(req_ready_o), 32'd1);
                chk("relock_err_sticky", 32'(err_o), 32'd1);
            end
        end
        run_req(v_zero, "after_relock");

        // Valid held high with a changing select while busy.
        wait_ready("hold");
        req_valid_i = 1'b1;
        req_sel_i   = 2'd3;
        req_dir_i   = 1'b0;
        req_steps_i = 8'd1;
        tick();
        rel = 1;
        flag = 1'b1;
        while (!done_o && rel < 100) begin
            if (phasesel_o !== 2'd3) flag = 1'b0;
            req_sel_i = 2'(rel);
            tick();
            rel++;
        end
        chk("hold_sel_const", 32'(flag), 32'd1);
        chk("hold_done_lat",  32'(rel),  32'd17);
        chk("hold_done_sel",  32'(phasesel_o), 32'd3);
        req_sel_i = 2'd2;
        tick();
        chk("hold_ready_after_done", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        chk("hold_second_busy", 32'(busy_o),     32'd1);
        chk("hold_second_sel",  32'(phasesel_o), 32'd2);
        rel = 0;
        while (!done_o && rel < 100) begin
            tick();
            rel++;
        end
        chk("hold_second_done", 32'(done_o), 32'd1);
        chk("hold_pos", pos_o, 32'h03FF0101);
        $display("req hold sel=3 then sel=2 pos=%08h", pos_o);

        // Asynchronous reset in the middle of a request.
        wait_ready("areset");
        req_valid_i = 1'b1;
        req_sel_i   = 2'd1;
        req_dir_i   = 1'b0;
        req_steps_i = 8'd3;
        tick();
        req_valid_i = 1'b0;
        repeat (10) tick();
        #2 rstn_i = 1'b0;
        #1;
        chk("areset_pos",  pos_o, 32'd0);
        chk("areset_outs", 32'({req_ready_o, phasesel_o, phasedir_o, phasestep_o, busy_o, done_o, err_o}), 32'd0);
        $display("req areset mid-operation pos=%08h busy=%0d", pos_o, busy_o);
        tick();
        rstn_i = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
